// File: rtl/y_misr_compactor.sv
// y_misr_compactor: folds a wide response vector into a MISR signature over a programmed sample count and flags a golden match.
module y_misr_compactor #(
  parameter int Y_WIDTH = 242,
  parameter int SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          num_samples,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic                 y_valid,
  input  logic [SIG_WIDTH-1:0] expect_sig,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic                 match,
  output logic [15:0]          sample_cnt
);
  localparam int NC = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PW = NC * SIG_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [15:0] num_lat;
  logic [15:0] cnt_inc;
  logic [PW-1:0] ypad;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] sig_next;
  logic accept;
  logic absorb;
  always_comb begin
    ypad = PW'(y);
    fold = '0;
    for (int i = 0; i < NC; i++) fold = fold ^ ypad[i*SIG_WIDTH +: SIG_WIDTH];
    sig_next = {signature[SIG_WIDTH-2:0], 1'b0} ^ (signature[SIG_WIDTH-1] ? POLY : '0) ^ fold;
  end
  assign cnt_inc = sample_cnt + 16'd1;
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  // done is the registered echo of DONE, so a start seen while it is high belongs to the old run
  always_comb begin
    next = state;
    accept = 1'b0;
    absorb = 1'b0;
    case (state)
      IDLE: if (start && !done) begin
        accept = 1'b1;
        next = num_samples == 16'd0 ? DONE : RUN;
      end
      RUN: if (y_valid) begin
        absorb = 1'b1;
        next = cnt_inc == num_lat ? DONE : RUN;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= SEED;
      sample_cnt <= '0;
      num_lat <= '0;
      match <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == DONE;
      if (accept) begin
        signature <= SEED;
        sample_cnt <= '0;
        match <= 1'b0;
        num_lat <= num_samples;
      end
      if (absorb) begin
        signature <= sig_next;
        sample_cnt <= cnt_inc;
      end
      if (state == DONE) match <= signature == expect_sig;
    end
  end
endmodule

// File: tb/tb_y_misr_compactor.sv
// tb_y_misr_compactor: scenario tasks with a signature scoreboard checked against an independent MISR model.
module tb_y_misr_compactor;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  logic clk, rst_n, start, y_valid, busy, done, match;
  logic [15:0] num_samples, sample_cnt;
  logic [241:0] y;
  logic [31:0] expect_sig, signature;
  logic [31:0] sb[$];
  int checks = 0;
  int failures = 0;

  y_misr_compactor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .y(y),
    .y_valid(y_valid), .expect_sig(expect_sig), .busy(busy), .done(done),
    .signature(signature), .match(match), .sample_cnt(sample_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] step(input logic [31:0] s, input logic [241:0] v);
    logic [255:0] p;
    logic [31:0] f;
    p = {14'd0, v};
    f = '0;
    for (int k = 0; k < 8; k++) f = f ^ p[32*k +: 32];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'd0) ^ f;
  endfunction

  function automatic logic [241:0] rnd();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
    return t[241:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] n);
    start = 1;
    num_samples = n;
    tick();
    start = 0;
  endtask

  task automatic feed(input logic [241:0] v, input logic vl);
    y = v;
    y_valid = vl;
    tick();
    y_valid = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
    checks++; if (signature !== SEED) begin failures++; $display("FAIL reset_sig got=%h exp=%h", signature, SEED); end
    checks++; if (sample_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", sample_cnt); end
    @(negedge clk) rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] e, s;
    expect_sig = 32'hFB3EE249;
    sb.push_back(32'hFB3EE249);
    start_run(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    feed('0, 1);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_end got busy=%b done=%b exp=0,0", busy, done); end
    wait_done(lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", lat); end
    e = sb.pop_front();
    checks++; if (signature !== e) begin failures++; $display("FAIL basic_sig got=%h exp=%h", signature, e); end
    checks++; if (sample_cnt !== 16'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", sample_cnt); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL basic_match got=%b exp=1", match); end
    s = signature;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", done); end
    checks++; if (match !== 1'b1 || signature !== s) begin failures++; $display("FAIL basic_hold got match=%b sig=%h exp 1,%h", match, signature, s); end
  endtask

  task automatic test_fold();
    int pos[3] = '{0, 32, 241};
    logic [31:0] ex[3] = '{32'hFB3EE248, 32'hFB3EE248, 32'hFB3CE249};
    logic [241:0] v;
    logic [31:0] e;
    int lat;
    expect_sig = '0;
    for (int i = 0; i < 3; i++) begin
      v = '0;
      v[pos[i]] = 1'b1;
      sb.push_back(ex[i]);
      start_run(1);
      feed(v, 1);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (signature !== e || lat !== 1) begin failures++; $display("FAIL fold_bit%0d got=%h lat=%0d exp=%h lat=1", pos[i], signature, lat, e); end
      tick();
    end
  endtask

  task automatic test_zero();
    expect_sig = SEED;
    start_run(0);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL zero_edge0 got busy=%b done=%b exp=0,0", busy, done); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done got done=%b busy=%b exp=1,0", done, busy); end
    checks++; if (signature !== SEED || sample_cnt !== 16'd0) begin failures++; $display("FAIL zero_state got sig=%h cnt=%0d exp=%h,0", signature, sample_cnt, SEED); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL zero_match got=%b exp=1", match); end
    tick();
  endtask

  task automatic test_gaps();
    logic [241:0] v[3];
    logic [31:0] e;
    int lat;
    e = SEED;
    for (int i = 0; i < 3; i++) begin
      v[i] = rnd();
      e = step(e, v[i]);
    end
    expect_sig = e;
    sb.push_back(e);
    start_run(3);
    feed(v[0], 1);
    feed(rnd(), 0);
    feed(rnd(), 0);
    feed(v[1], 1);
    checks++; if (sample_cnt !== 16'd2) begin failures++; $display("FAIL gaps_cnt_mid got=%0d exp=2", sample_cnt); end
    feed(rnd(), 0);
    feed(v[2], 1);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL gaps_latency got=%0d exp=1", lat); end
    checks++; if (signature !== e || sample_cnt !== 16'd3 || match !== 1'b1) begin failures++; $display("FAIL gaps_sig got=%h cnt=%0d m=%b exp=%h,3,1", signature, sample_cnt, match, e); end
    tick();
    sb.push_back(step(step(step(SEED, v[0]), v[1]), v[2]));
    start_run(3);
    for (int i = 0; i < 3; i++) feed(v[i], 1);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (signature !== e || lat !== 1) begin failures++; $display("FAIL nogap_sig got=%h lat=%0d exp=%h lat=1", signature, lat, e); end
    tick();
  endtask

  task automatic test_ignore();
    logic [241:0] v[4];
    logic [31:0] e;
    int lat;
    e = SEED;
    for (int i = 0; i < 4; i++) begin
      v[i] = rnd();
      e = step(e, v[i]);
    end
    expect_sig = e ^ 32'd1;
    sb.push_back(e);
    start_run(4);
    feed(v[0], 1);
    start = 1;
    num_samples = 2;
    feed(v[1], 1);
    start = 0;
    num_samples = 9;
    checks++; if (busy !== 1'b1 || sample_cnt !== 16'd2) begin failures++; $display("FAIL ignore_mid got busy=%b cnt=%0d exp=1,2", busy, sample_cnt); end
    feed(v[2], 1);
    feed(v[3], 1);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (signature !== e || sample_cnt !== 16'd4 || lat !== 1) begin failures++; $display("FAIL ignore_sig got=%h cnt=%0d lat=%0d exp=%h,4,1", signature, sample_cnt, lat, e); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL ignore_match got=%b exp=0", match); end
    tick();
  endtask

  task automatic test_midrun_reset();
    logic [241:0] v[5];
    logic [31:0] e;
    int lat, seen;
    e = SEED;
    for (int i = 0; i < 5; i++) begin
      v[i] = rnd();
      e = step(e, v[i]);
    end
    expect_sig = e;
    start_run(5);
    feed(v[0], 1);
    feed(v[1], 1);
    #2 rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0) begin failures++; $display("FAIL rst_async_ctl got busy=%b done=%b match=%b exp=0,0,0", busy, done, match); end
    checks++; if (signature !== SEED || sample_cnt !== 16'd0) begin failures++; $display("FAIL rst_async_data got sig=%h cnt=%0d exp=%h,0", signature, sample_cnt, SEED); end
    @(negedge clk) rst_n = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", seen); end
    sb.push_back(e);
    start_run(5);
    for (int i = 0; i < 5; i++) feed(v[i], 1);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (signature !== e || match !== 1'b1 || lat !== 1) begin failures++; $display("FAIL rst_rerun got=%h m=%b lat=%0d exp=%h,1,1", signature, match, lat, e); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [241:0] a, b, c, d;
    logic [31:0] e;
    int lat;
    a = rnd(); b = rnd(); c = rnd(); d = rnd();
    sb.push_back(step(step(SEED, a), b));
    expect_sig = '0;
    start_run(2);
    feed(a, 1);
    feed(b, 1);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (signature !== e || lat !== 1) begin failures++; $display("FAIL b2b_first got=%h lat=%0d exp=%h,1", signature, lat, e); end
    start_run(2);
    checks++; if (busy !== 1'b0 || signature !== e) begin failures++; $display("FAIL b2b_start_on_done got busy=%b sig=%h exp=0,%h", busy, signature, e); end
    sb.push_back(step(step(SEED, c), d));
    start_run(2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", busy); end
    feed(c, 1);
    feed(d, 1);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (signature !== e || sample_cnt !== 16'd2 || lat !== 1) begin failures++; $display("FAIL b2b_second got=%h cnt=%0d lat=%0d exp=%h,2,1", signature, sample_cnt, lat, e); end
    tick();
  endtask

  initial begin
    rst_n = 0; start = 0; y_valid = 0; y = '0; num_samples = '0; expect_sig = '0;
    test_reset();
    test_basic();
    test_fold();
    test_zero();
    test_gaps();
    test_ignore();
    test_midrun_reset();
    test_back_to_back();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/y_misr_compactor.md
# y_misr_compactor

Downstream response compactor for the identity-simulation bench: it samples the 242-bit `y` output of the synthesized `top` on each valid clock edge. It folds each sample into a 32-bit multiple-input signature register (MISR) and, after a programmed number of samples, compares the signature with an expected value. This replaces per-cycle `$strobe` dumps with a single pass/fail signature, so simulation and synthesis runs are compared by one word.

## Interface
- `Y_WIDTH`, 242, width of the consumed response vector `y`
- `SIG_WIDTH`, 32, signature width; fold chunk size
- `POLY`, 32'h04C11DB7, MISR feedback polynomial (taps XORed in when MSB shifts out)
- `SEED`, 32'hFFFFFFFF, signature value loaded on `start`
- `clk` in 1: the single clock. Reset is asynchronous and active-low (`rst_n`). The polarity and synchronicity are fixed.
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: begin a compaction run (sampled only in IDLE)
- `num_samples` in 16: number of valid samples to absorb; latched on accepted `start`
- `y` in Y_WIDTH: response vector from `top`
- `y_valid` in 1: `y` is a sample this cycle
- `expect_sig` in SIG_WIDTH: golden signature; sampled in the cycle the run completes
- `busy` out 1: run in progress (RUN state)
- `done` out 1: one-cycle completion pulse
- `signature` out SIG_WIDTH: current/final MISR value
- `match` out 1: `signature == expect_sig`, valid from `done` until next accepted `start`
- `sample_cnt` out 16: samples absorbed in the current/last run

## Operation
- Fold: pad `y` with zeros to ceil(Y_WIDTH/SIG_WIDTH)*SIG_WIDTH bits (256 for the defaults, 14 zero MSBs). XOR all SIG_WIDTH chunks together; chunk k is bits [32k+31:32k].
- MISR step: `sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(y)`.
- FSM states:
  - IDLE:
    - `start` → load `signature=SEED`, `sample_cnt=0`, `match=0`, latch `num_samples`.
    - Go to DONE if the latched count is 0, else RUN.
  - RUN:
    - Each cycle with `y_valid=1`: one MISR step, `sample_cnt+1`.
    - When that step makes `sample_cnt == num_samples`: go to DONE.
    - `y_valid=0`: hold everything.
  - DONE (one cycle):
    - `done=1`.
    - `match` is registered from `signature == expect_sig`, using the final signature.
    - Go to IDLE.
- `start` in RUN or DONE is ignored; `num_samples` changes mid-run are ignored.
- `y_valid` in IDLE or DONE is ignored; no MISR update.
- `signature`, `sample_cnt` and `match` hold after DONE until the next accepted `start`.
- `sample_cnt` saturates logically at `num_samples`; no wrap within a run (max run 65535 samples).

## Timing
- Reset (async assert, synchronous-release expected upstream): state IDLE, `busy=0`, `done=0`, `match=0`, `signature=SEED`, `sample_cnt=0`.
- `start` at edge 0 → `busy=1` after edge 0. The first sample can be absorbed at edge 1.
- Last valid sample absorbed at edge k → DONE during cycle k..k+1. `done=1` and `match` are updated after edge k+1; `busy=0` after edge k.
- `num_samples=0`: `start` at edge 0 → `done=1` after edge 1, `signature=SEED`.
- Throughput: one sample per cycle, no bubbles required.
- Reset mid-run: immediate return to reset values. The partial signature is discarded and no `done` pulse is produced.
- `start` coincident with `done`: ignored; a new run needs `start` in IDLE (≥1 cycle after `done`).

## Test plan
- Reset then `start`, `num_samples=1`, `y=0`, `y_valid=1` → `signature=32'hFB3EE249`, `sample_cnt=1`, `done` one cycle. With `expect_sig=32'hFB3EE249`, `match=1`.
- Fold check, `num_samples=1`:
  - `y` with only bit 0 set → `32'hFB3EE248`.
  - Only bit 32 set → `32'hFB3EE248`.
  - Only bit 241 set → `32'hFB3CE249`.
- `num_samples=0` → `done` one cycle after `start`, `signature=32'hFFFFFFFF`, `busy` never asserted, `sample_cnt=0`.
- `num_samples=3` with `y_valid` pattern 1,0,0,1,0,1 → exactly 3 MISR steps, `done` one cycle after the third valid, same signature as the gap-free run.
- `start` pulsed during RUN and `num_samples` changed mid-run → no restart, run completes on the originally latched count. `expect_sig` off by one bit → `match=0`.
- `rst_n` low during RUN after 2 of 5 samples → outputs return to reset values asynchronously, no `done`. A subsequent full run produces the same signature as a clean run.
